// File: rtl/decodificador_hamming_pipe_pkg.sv
// Shared definitions for the pipelined SECDED Hamming decoder: check-bit
// count, codeword position helpers and the stage-2 result record.
package hamming_pkg;

  // Widest supported configuration: 57 data bits need 6 check bits (N = 63).
  localparam int DATA_W_MAX = 57;
  localparam int R_MAX      = 6;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_r(input int data_w);
    int r;
    r = 0;
    for (int k = 1; k <= 7; k++) begin
      if ((r == 0) && ((1 << k) >= (data_w + k + 1))) begin
        r = k;
      end
    end
    return r;
  endfunction

  // Check bits occupy the power-of-two positions.
  function automatic bit es_pot2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position holding data bit idx (data fills non-power-of-two
  // positions in ascending order, dato[0] lowest).
  function automatic int pos_dato(input int idx);
    int cuenta;
    int res;
    cuenta = 0;
    res    = 0;
    for (int p = 1; p < 128; p++) begin
      if (!es_pot2(p)) begin
        if ((cuenta == idx) && (res == 0)) begin
          res = p;
        end
        cuenta++;
      end
    end
    return res;
  endfunction

  // Positions 1..n whose index has bit b set; syndrome bit b is the XOR of
  // the codeword masked with this vector.
  function automatic logic [63:0] mascara_sindrome(input int b, input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 1; i < 64; i++) begin
      if ((i <= n) && (((i >> b) & 1) == 1)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Stage-2 result, sized for the widest configuration; narrower
  // instances leave the upper bits at zero.
  typedef struct packed {
    logic [DATA_W_MAX-1:0] dato;
    logic [R_MAX-1:0]      sindrome;
    logic                  error_simple;
    logic                  error_doble;
  } resultado_t;

endpackage

// File: rtl/decodificador_hamming_pipe_if.sv
// Stream bundle between the received-word source, the decoder and the
// display logic. "slave" is the decoder's view, "master" the environment's.
interface decodificador_hamming_pipe_if
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4
);

  localparam int R = calc_r(DATA_W);
  localparam int N = DATA_W + R;

  logic              en_valido;
  logic              en_listo;
  logic [N:0]        palabra_rx;
  logic              sal_valido;
  logic              sal_listo;
  logic [DATA_W-1:0] dato;
  logic [R-1:0]      sindrome;
  logic              error_simple;
  logic              error_doble;

  modport slave (
    input  en_valido, palabra_rx, sal_listo,
    output en_listo, sal_valido, dato, sindrome, error_simple, error_doble
  );

  modport master (
    output en_valido, palabra_rx, sal_listo,
    input  en_listo, sal_valido, dato, sindrome, error_simple, error_doble
  );

endinterface

// File: rtl/decodificador_hamming_pipe_sindrome.sv
// Combinational syndrome and overall-parity generator for an N+1 bit
// extended-Hamming codeword (bit 0 = overall parity).
module hamming_sindrome
  import hamming_pkg::*;
#(
  parameter int N = 7,
  parameter int R = 3
) (
  input  logic [N:0]   palabra_i,
  output logic [R-1:0] sindrome_o,
  output logic         paridad_o
);

  // Each syndrome bit is the parity of the positions whose index has that bit set.
  for (genvar gi = 0; gi < R; gi++) begin : g_sindrome
    localparam logic [63:0] MASCARA = mascara_sindrome(gi, N);
    assign sindrome_o[gi] = ^(palabra_i & MASCARA[N:0]);
  end

  // Overall parity over every bit, including the parity bit itself.
  assign paridad_o = ^palabra_i;

endmodule

// File: rtl/decodificador_hamming_pipe.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready stream.
// Stage 1 registers the raw word, its syndrome and overall parity;
// stage 2 classifies, corrects and registers the result.
// Optional saturating error counters: define HAMMING_CONTADORES_EN.
module decodificador_hamming_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  decodificador_hamming_pipe_if.slave  bus
`ifdef HAMMING_CONTADORES_EN
  ,
  input  logic                         limpiar_cnt,
  output logic [CNT_W-1:0]             cnt_simple,
  output logic [CNT_W-1:0]             cnt_doble
`endif
);

  localparam int R = calc_r(DATA_W);
  localparam int N = DATA_W + R;
  localparam logic [R-1:0] N_SIN = R'(N);

  // Pipeline state
  logic              v1_q;
  logic [N:0]        pal1_q;
  logic [R-1:0]      sin1_q;
  logic              par1_q;
  logic              v2_q;
  resultado_t        res_q;
  resultado_t        res_d;

  // Combinational helpers
  logic              listo1;
  logic              listo2;
  logic [R-1:0]      sin_w;
  logic              par_w;
  logic [N:0]        corr;
  logic [DATA_W-1:0] dato_ext;
  logic              es_simple;
  logic              es_doble;

  // Ready chain: a stage may load when it is empty or its successor drains.
  assign listo2       = !v2_q || bus.sal_listo;
  assign listo1       = !v1_q || listo2;
  assign bus.en_listo = listo1;

  hamming_sindrome #(
    .N (N),
    .R (R)
  ) u_sindrome (
    .palabra_i  (bus.palabra_rx),
    .sindrome_o (sin_w),
    .paridad_o  (par_w)
  );

  // Stage 1: capture word, syndrome and parity whenever the stage may advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      pal1_q <= '0;
      sin1_q <= '0;
      par1_q <= 1'b0;
    end else if (listo1) begin
      v1_q <= bus.en_valido;
      if (bus.en_valido) begin
        pal1_q <= bus.palabra_rx;
        sin1_q <= sin_w;
        par1_q <= par_w;
      end
    end
  end

  // Classification and single-bit correction of the stage-1 word.
  // A syndrome beyond N with odd parity cannot be a single error.
  always_comb begin
    corr      = pal1_q;
    es_simple = 1'b0;
    es_doble  = 1'b0;
    if (par1_q) begin
      if (sin1_q == '0) begin
        es_simple = 1'b1;
      end else if (sin1_q <= N_SIN) begin
        corr[sin1_q] = ~pal1_q[sin1_q];
        es_simple    = 1'b1;
      end else begin
        es_doble = 1'b1;
      end
    end else if (sin1_q != '0) begin
      es_doble = 1'b1;
    end
  end

  // Data extraction from the non-power-of-two positions.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extrae
    localparam int POS = pos_dato(gi);
    assign dato_ext[gi] = corr[POS];
  end

  // Assemble the stage-2 result record.
  always_comb begin
    res_d                    = '0;
    res_d.dato[DATA_W-1:0]   = dato_ext;
    res_d.sindrome[R-1:0]    = sin1_q;
    res_d.error_simple       = es_simple;
    res_d.error_doble        = es_doble;
  end

  // Stage 2: holds the result stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q  <= 1'b0;
      res_q <= '0;
    end else if (listo2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        res_q <= res_d;
      end
    end
  end

  assign bus.sal_valido   = v2_q;
  assign bus.dato         = res_q.dato[DATA_W-1:0];
  assign bus.sindrome     = res_q.sindrome[R-1:0];
  assign bus.error_simple = res_q.error_simple;
  assign bus.error_doble  = res_q.error_doble;

  // Padding bits of the shared record are constant; fold them so every bit is read.
  logic unused_res;
  assign unused_res = ^res_q;

`ifdef HAMMING_CONTADORES_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             handshake;
  logic [CNT_W-1:0] cnt_simple_q;
  logic [CNT_W-1:0] cnt_simple_d;
  logic [CNT_W-1:0] cnt_doble_q;
  logic [CNT_W-1:0] cnt_doble_d;

  assign handshake = v2_q && bus.sal_listo;

  // Next counts: clear beats increment; increments saturate at all-ones.
  always_comb begin
    cnt_simple_d = cnt_simple_q;
    cnt_doble_d  = cnt_doble_q;
    if (limpiar_cnt) begin
      cnt_simple_d = '0;
      cnt_doble_d  = '0;
    end else begin
      if (handshake && res_q.error_simple && (cnt_simple_q != CNT_MAX)) begin
        cnt_simple_d = cnt_simple_q + CNT_W'(1);
      end
      if (handshake && res_q.error_doble && (cnt_doble_q != CNT_MAX)) begin
        cnt_doble_d = cnt_doble_q + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_simple_q <= '0;
      cnt_doble_q  <= '0;
    end else begin
      cnt_simple_q <= cnt_simple_d;
      cnt_doble_q  <= cnt_doble_d;
    end
  end

  assign cnt_simple = cnt_simple_q;
  assign cnt_doble  = cnt_doble_q;
`else
  // Counter width only matters when the counters are built.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_decodificador_hamming_pipe.sv
// Directed bench for decodificador_hamming_pipe: a DATA_W=4 and a DATA_W=8
// instance share clock and reset. Counter checks exist when
// HAMMING_CONTADORES_EN is defined.
module tb_decodificador_hamming_pipe;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  decodificador_hamming_pipe_if #(.DATA_W(4)) bus4 ();
  decodificador_hamming_pipe_if #(.DATA_W(8)) bus8 ();

`ifdef HAMMING_CONTADORES_EN
  logic       limpiar4;
  logic       limpiar8;
  logic [7:0] cnt_s4;
  logic [7:0] cnt_d4;
  logic [7:0] cnt_s8;
  logic [7:0] cnt_d8;
`endif

  decodificador_hamming_pipe #(.DATA_W(4), .CNT_W(8)) u4 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus4)
`ifdef HAMMING_CONTADORES_EN
    ,
    .limpiar_cnt (limpiar4),
    .cnt_simple  (cnt_s4),
    .cnt_doble   (cnt_d4)
`endif
  );

  decodificador_hamming_pipe #(.DATA_W(8), .CNT_W(8)) u8 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus8)
`ifdef HAMMING_CONTADORES_EN
    ,
    .limpiar_cnt (limpiar8),
    .cnt_simple  (cnt_s8),
    .cnt_doble   (cnt_d8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated word through the DATA_W=4 instance, latency checked.
  task automatic vec4(input string tag, input logic [7:0] w, input logic [3:0] ed,
                      input logic [2:0] es, input logic esim, input logic edob);
    bus4.en_valido  = 1'b1;
    bus4.palabra_rx = w;
    bus4.sal_listo  = 1'b1;
    tick();
    bus4.en_valido = 1'b0;
    chk({tag, "_lat"}, 64'(bus4.sal_valido), 64'(0));
    tick();
    chk({tag, "_valid"}, 64'(bus4.sal_valido), 64'(1));
    chk({tag, "_dato"}, 64'(bus4.dato), 64'(ed));
    chk({tag, "_sind"}, 64'(bus4.sindrome), 64'(es));
    chk({tag, "_simple"}, 64'(bus4.error_simple), 64'(esim));
    chk({tag, "_doble"}, 64'(bus4.error_doble), 64'(edob));
    $display("txn %s word=%02h dato=%h sind=%0d s=%0b d=%0b", tag, w, bus4.dato,
             bus4.sindrome, bus4.error_simple, bus4.error_doble);
    tick();
  endtask

  task automatic vec8(input string tag, input logic [12:0] w, input logic [7:0] ed,
                      input logic [3:0] es, input logic esim, input logic edob);
    bus8.en_valido  = 1'b1;
    bus8.palabra_rx = w;
    bus8.sal_listo  = 1'b1;
    tick();
    bus8.en_valido = 1'b0;
    chk({tag, "_lat"}, 64'(bus8.sal_valido), 64'(0));
    tick();
    chk({tag, "_valid"}, 64'(bus8.sal_valido), 64'(1));
    chk({tag, "_dato"}, 64'(bus8.dato), 64'(ed));
    chk({tag, "_sind"}, 64'(bus8.sindrome), 64'(es));
    chk({tag, "_simple"}, 64'(bus8.error_simple), 64'(esim));
    chk({tag, "_doble"}, 64'(bus8.error_doble), 64'(edob));
    $display("txn %s word=%04h dato=%h sind=%0d s=%0b d=%0b", tag, w, bus8.dato,
             bus8.sindrome, bus8.error_simple, bus8.error_doble);
    tick();
  endtask

  // Valid DATA_W=4 codewords for data 1..6.
  logic [7:0] bp_w [6];
  logic [3:0] bp_d [6];
  int         in_idx;
  int         out_idx;
  logic       held_v;
  logic [3:0] held_dato;

  initial begin
    n_cmp = 0;
    n_err = 0;
    bp_w = '{8'h0F, 8'h33, 8'h3C, 8'h55, 8'h5A, 8'h66};
    bp_d = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    rst = 1'b1;
    bus4.en_valido = 1'b0; bus4.palabra_rx = '0; bus4.sal_listo = 1'b0;
    bus8.en_valido = 1'b0; bus8.palabra_rx = '0; bus8.sal_listo = 1'b0;
`ifdef HAMMING_CONTADORES_EN
    limpiar4 = 1'b0;
    limpiar8 = 1'b0;
`endif
    tick();
    tick();

    // Reset state
    chk("rst_valid4", 64'(bus4.sal_valido), 64'(0));
    chk("rst_dato4", 64'(bus4.dato), 64'(0));
    chk("rst_sind4", 64'(bus4.sindrome), 64'(0));
    chk("rst_flags4", 64'({bus4.error_simple, bus4.error_doble}), 64'(0));
    chk("rst_valid8", 64'(bus8.sal_valido), 64'(0));
`ifdef HAMMING_CONTADORES_EN
    chk("rst_cnt4", 64'({cnt_s4, cnt_d4}), 64'(0));
`endif
    rst = 1'b0;
    tick();
    chk("post_rst_listo4", 64'(bus4.en_listo), 64'(1));
    chk("post_rst_listo8", 64'(bus8.en_listo), 64'(1));

    // DATA_W=4 directed vectors
    vec4("d4_clean", 8'b11000011, 4'b1100, 3'd0, 1'b0, 1'b0);
    vec4("d4_bit5", 8'b11100011, 4'b1100, 3'd5, 1'b1, 1'b0);
`ifdef HAMMING_CONTADORES_EN
    chk("d4_cnt_simple_1", 64'(cnt_s4), 64'(1));
`endif
    vec4("d4_bit0", 8'b11000010, 4'b1100, 3'd0, 1'b1, 1'b0);
    vec4("d4_double", 8'b10100011, 4'b1010, 3'd3, 1'b0, 1'b1);
`ifdef HAMMING_CONTADORES_EN
    chk("d4_cnt_simple_2", 64'(cnt_s4), 64'(2));
    chk("d4_cnt_doble_1", 64'(cnt_d4), 64'(1));
`endif

    // DATA_W=8 (N=12) directed vectors
    vec8("d8_clean", 13'h0000, 8'h00, 4'd0, 1'b0, 1'b0);
    vec8("d8_syn13", 13'h0112, 8'h00, 4'd13, 1'b0, 1'b1);
    vec8("d8_bit12", 13'h1000, 8'h00, 4'd12, 1'b1, 1'b0);
`ifdef HAMMING_CONTADORES_EN
    chk("d8_cnt_doble_1", 64'(cnt_d8), 64'(1));
`endif

    // 300 back-to-back single errors at positions 0..12
    bus8.sal_listo = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus8.en_valido  = 1'b1;
      bus8.palabra_rx = 13'd1 << (i % 13);
      tick();
      if (i >= 1) begin
        chk("d8_stream_sind", 64'(bus8.sindrome), 64'((i - 1) % 13));
        chk("d8_stream_simple", 64'(bus8.error_simple), 64'(1));
      end
    end
    bus8.en_valido = 1'b0;
    tick();
    tick();
    $display("txn d8_stream words=300 last_sind=%0d", bus8.sindrome);
`ifdef HAMMING_CONTADORES_EN
    chk("d8_cnt_simple_sat", 64'(cnt_s8), 64'(255));
`endif

    // Clear coinciding with an increment
    bus8.en_valido  = 1'b1;
    bus8.palabra_rx = 13'h0008;
    tick();
    bus8.en_valido = 1'b0;
    tick();
    chk("d8_clr_valid", 64'(bus8.sal_valido), 64'(1));
`ifdef HAMMING_CONTADORES_EN
    limpiar8 = 1'b1;
`endif
    tick();
`ifdef HAMMING_CONTADORES_EN
    limpiar8 = 1'b0;
    chk("d8_clr_cnt_simple", 64'(cnt_s8), 64'(0));
    chk("d8_clr_cnt_doble", 64'(cnt_d8), 64'(0));
`endif
    $display("txn d8_clear done");

    // Back-pressure: 6 words, consumer stalled in cycles 3..5
    in_idx    = 0;
    out_idx   = 0;
    held_v    = 1'b0;
    held_dato = '0;
    for (int c = 0; c < 30; c++) begin
      bus4.sal_listo  = !((c >= 3) && (c <= 5));
      bus4.en_valido  = (in_idx < 6);
      bus4.palabra_rx = (in_idx < 6) ? bp_w[in_idx] : 8'h00;
      #1;
      if ((c >= 3) && (c <= 5)) begin
        chk("bp_en_listo_stall", 64'(bus4.en_listo), 64'(0));
      end
      if (held_v) begin
        chk("bp_hold_valid", 64'(bus4.sal_valido), 64'(1));
        chk("bp_hold_dato", 64'(bus4.dato), 64'(held_dato));
      end
      held_v    = bus4.sal_valido && !bus4.sal_listo;
      held_dato = bus4.dato;
      if (bus4.sal_valido && bus4.sal_listo) begin
        if (out_idx < 6) begin
          chk("bp_order", 64'(bus4.dato), 64'(bp_d[out_idx]));
        end
        $display("txn bp_out idx=%0d dato=%h", out_idx, bus4.dato);
        out_idx++;
      end
      if (bus4.en_valido && bus4.en_listo) begin
        in_idx++;
      end
      tick();
    end
    chk("bp_in_count", 64'(in_idx), 64'(6));
    chk("bp_out_count", 64'(out_idx), 64'(6));

    // Reset in the middle of a stalled stream
    bus4.sal_listo  = 1'b0;
    bus4.en_valido  = 1'b1;
    bus4.palabra_rx = 8'h0F;
    tick();
    tick();
    tick();
    chk("mid_full_valid", 64'(bus4.sal_valido), 64'(1));
    chk("mid_full_listo", 64'(bus4.en_listo), 64'(0));
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(bus4.sal_valido), 64'(0));
    chk("mid_rst_listo", 64'(bus4.en_listo), 64'(1));
    chk("mid_rst_dato", 64'(bus4.dato), 64'(0));
    $display("txn mid_reset valid=%0b listo=%0b", bus4.sal_valido, bus4.en_listo);
    rst = 1'b0;
    bus4.en_valido = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
